// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access path.
package lc3_mem_pkg;

   localparam int DATA_W_DEF = 16;

   localparam logic ACC_READ  = 1'b0;
   localparam logic ACC_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/lc3_addr_adder.sv
// Effective-address adder; carry out is dropped so addresses wrap.
module lc3_addr_adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/lc3_mem_access_unit.sv
// Forms ADDR1+ADDR2 into MAR and runs one bounded SRAM access.
module lc3_mem_access_unit
   import lc3_mem_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 8
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              start,
   input  logic              rw,
   input  logic [DATA_W-1:0] addr1_in,
   input  logic [DATA_W-1:0] addr2_in,
   input  logic [DATA_W-1:0] wdata,
   input  logic              mem_rdy,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q;
   state_e            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              rw_q;
   logic [DATA_W-1:0] ea;
   logic              timeout_hit;

   lc3_addr_adder #(.W(DATA_W)) u_adder (
      .a   (addr1_in),
      .b   (addr2_in),
      .sum (ea)
   );

   assign timeout_hit = (cnt_q == CNT_LAST) && !mem_rdy;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start) state_d = ST_ACCESS;
         ST_ACCESS: if (mem_rdy || timeout_hit) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         MAR   <= '0;
         MDR   <= '0;
         cnt_q <= '0;
         err   <= 1'b0;
         rw_q  <= ACC_READ;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  MAR   <= ea;
                  rw_q  <= rw;
                  err   <= 1'b0;
                  cnt_q <= '0;
                  if (rw == ACC_WRITE) MDR <= wdata;
               end
            end
            ST_ACCESS: begin
               // a late mem_rdy still beats the timeout on the same edge
               if (mem_rdy) begin
                  if (rw_q == ACC_READ) MDR <= mem_rdata;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (timeout_hit) err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign mem_ce    = (state_q == ST_ACCESS);
   assign mem_we    = mem_ce && (rw_q == ACC_WRITE);
   assign mem_addr  = MAR;
   assign mem_wdata = MDR;

endmodule
